// File: rtl/const_load_pkg.sv
// Shared types and encodings for the load-constant controller:
// FSM states, request opcodes and constant-ALU format codes.
package const_load_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC_L,
    ST_EXEC_H,
    ST_EXEC_P,
    ST_WRITE
  } state_t;

  localparam logic [1:0] OP_LCL  = 2'b00;
  localparam logic [1:0] OP_LCH  = 2'b01;
  localparam logic [1:0] OP_PASS = 2'b10;
  localparam logic [1:0] OP_LD16 = 2'b11;

  localparam logic [1:0] FMT_NONE = 2'b00;
  localparam logic [1:0] FMT_PASS = 2'b01;
  localparam logic [1:0] FMT_BYTE = 2'b11;

endpackage

// File: rtl/const_load_ctrl.sv
// Sequences load-constant requests (byte low/high, pass, 16-bit load) through an
// external constant ALU and register file, producing exactly one write per request.
module const_load_ctrl
  import const_load_pkg::*;
#(
  parameter int bits_palavra = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [2:0]              req_rd,
  input  logic [bits_palavra-1:0] req_const,
  output logic [2:0]              rf_rd_addr,
  input  logic [bits_palavra-1:0] rf_rd_data,
  output logic [bits_palavra-1:0] alu_dado,
  output logic [bits_palavra-1:0] alu_const,
  output logic [1:0]              alu_formato,
  output logic                    alu_r,
  input  logic [bits_palavra-1:0] alu_result,
  output logic                    rf_we,
  output logic [2:0]              rf_wr_addr,
  output logic [bits_palavra-1:0] rf_wr_data,
  output logic                    busy,
  output logic                    done
);

  state_t                  state, state_nx;
  logic [1:0]              op_q;
  logic [2:0]              rd_q;
  logic [bits_palavra-1:0] cst_q;
  logic [bits_palavra-1:0] operand;
  logic                    ready_en;
  logic                    accept;

  // ready_en keeps req_ready low until the first clock edge after reset release
  assign req_ready = ready_en && (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      cst_q    <= '0;
      operand  <= '0;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nx;
      ready_en <= 1'b1;
      if (accept) begin
        op_q  <= req_op;
        rd_q  <= req_rd;
        cst_q <= req_const;
      end
      case (state)
        ST_READ:                           operand <= rf_rd_data;
        ST_EXEC_L, ST_EXEC_H, ST_EXEC_P:   operand <= alu_result;
        default:                           operand <= operand;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_op == OP_PASS) state_nx = ST_EXEC_P;
          else                   state_nx = ST_READ;
        end
      end
      ST_READ:   state_nx = (op_q == OP_LCH) ? ST_EXEC_H : ST_EXEC_L;
      ST_EXEC_L: state_nx = (op_q == OP_LD16) ? ST_EXEC_H : ST_WRITE;
      ST_EXEC_H: state_nx = ST_WRITE;
      ST_EXEC_P: state_nx = ST_WRITE;
      ST_WRITE:  state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // For LD16 the EXEC_H operand is the EXEC_L result already held in operand
  always_comb begin
    alu_formato = FMT_NONE;
    alu_r       = 1'b0;
    alu_const   = '0;
    alu_dado    = operand;
    rf_rd_addr  = '0;
    rf_we       = 1'b0;
    rf_wr_addr  = '0;
    rf_wr_data  = '0;
    done        = 1'b0;
    case (state)
      ST_READ: rf_rd_addr = rd_q;
      ST_EXEC_L: begin
        alu_formato = FMT_BYTE;
        alu_const   = {8'h00, cst_q[7:0]};
      end
      ST_EXEC_H: begin
        alu_formato = FMT_BYTE;
        alu_r       = 1'b1;
        alu_const   = {cst_q[15:8], 8'h00};
      end
      ST_EXEC_P: begin
        alu_formato = FMT_PASS;
        alu_const   = cst_q;
      end
      ST_WRITE: begin
        rf_we      = 1'b1;
        rf_wr_addr = rd_q;
        rf_wr_data = operand;
        done       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/const_load_ctrl.md
CONST_LOAD_CTRL -- requirements
Module: const_load_ctrl

Interface
REQ-001 Parameter: bits_palavra, 16, datapath word width; all byte positions below assume 16.
REQ-002 clk  in  1  single clock, rising-edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  load-constant request present.
REQ-005 req_ready  out  1  controller idle and able to accept.
REQ-006 req_op  in  2  00 LCL, 01 LCH, 10 PASS, 11 LD16.
REQ-007 req_rd  in  3  destination register index.
REQ-008 req_const  in  16  immediate; LCL uses [7:0], LCH uses [15:8], PASS/LD16 use [15:0].
REQ-009 rf_rd_addr  out  3  register-file read index; read data is combinational.
REQ-010 rf_rd_data  in  16  register-file read data.
REQ-011 alu_dado, alu_const  out  16 each  constant-ALU operands.
REQ-012 alu_formato  out  2, alu_r  out  1  constant-ALU format (01 pass, 11 byte load) and byte select (0 low, 1 high).
REQ-013 alu_result  in  16  constant-ALU combinational result.
REQ-014 rf_we  out  1, rf_wr_addr  out  3, rf_wr_data  out  16  register-file write port, committed at the clk edge while rf_we=1.
REQ-015 busy  out  1  not idle; done  out  1  one-cycle pulse coincident with rf_we.

Function
REQ-016 Handshake: a request is accepted on the rising edge where req_valid=1 and req_ready=1; req_ready=1 only in IDLE.
REQ-017 req_op, req_rd and req_const are latched at acceptance; later input changes do not affect the operation in flight.
REQ-018 FSM states: IDLE, READ, EXEC_L, EXEC_H, EXEC_P, WRITE.
REQ-019 Transitions from IDLE on accept: LCL and LD16 go to READ then EXEC_L; LCH goes to READ then EXEC_H; PASS goes directly to EXEC_P.
REQ-020 From EXEC_L: LD16 goes to EXEC_H, otherwise WRITE; EXEC_H and EXEC_P go to WRITE; WRITE goes to IDLE.
REQ-021 READ: rf_rd_addr=latched rd; rf_rd_data is captured into the operand register at the end of READ.
REQ-022 EXEC_L: alu_formato=11, alu_r=0, alu_const={8'h00, const[7:0]}, alu_dado=operand; alu_result is captured into the operand register.
REQ-023 EXEC_H: alu_formato=11, alu_r=1, alu_const={const[15:8], 8'h00}, alu_dado=operand; alu_result is captured. For LD16, the operand is the EXEC_L result, with no register-file re-read.
REQ-024 EXEC_P: alu_formato=01, alu_const=const[15:0]; alu_result is captured.
REQ-025 Outside EXEC_* states: alu_formato=00, alu_r=0, alu_const=0, alu_dado=operand.
REQ-026 WRITE: rf_we=1, rf_wr_addr=latched rd, rf_wr_data=operand register, done=1; each request produces exactly one write.
REQ-027 Latency is counted from the accept edge E0 to the commit edge: PASS commits at E2, LCL/LCH at E3, LD16 at E4. req_ready rises in the cycle after WRITE.
REQ-028 busy = (state != IDLE).
REQ-029 Back-to-back requests to the same rd: the second READ occurs after the first write has committed, so it sees the updated value; no forwarding is needed.
REQ-030 req_valid while busy is ignored; the request stays pending until accepted and is never dropped or duplicated.

Reset
REQ-031 While rst_n=0: state=IDLE, operand and latched request fields=0.
REQ-032 While rst_n=0, outputs: req_ready=0, busy=0, rf_we=0, done=0, all alu_* and rf_* outputs=0.
REQ-033 req_ready rises on the first clk edge after rst_n deasserts.
REQ-034 Reset mid-operation aborts the operation with no write; the aborted request is not resumed.

Structure
REQ-035 A shared package const_load_pkg holds the state enum, the req_op encodings (OP_LCL, OP_LCH, OP_PASS, OP_LD16) and the format codes (FMT_NONE=00, FMT_PASS=01, FMT_BYTE=11).
REQ-036 No sub-module; the constant ALU and the register file stay external, connected through the alu_* and rf_* ports.

Verification
REQ-037 LCL: reg3=0xABCD, req_const=0x0012 -> alu_const=0x0012, formato=11, r=0; write reg3=0xAB12 at E3 with done=1.
REQ-038 LCH: reg3=0xABCD, req_const=0x3400 -> alu_const=0x3400, r=1; write reg3=0x34CD at E3.
REQ-039 LD16: reg5=0xFFFF, req_const=0x5678 -> EXEC_L result 0xFF78, EXEC_H result 0x5678; exactly one write, reg5=0x5678 at E4.
REQ-040 PASS to reg0 with 0xBEEF, req_valid held high, then LCL 0x0011 to reg0 -> write 0xBEEF at E2, second accept one cycle after WRITE, then reg0=0xBE11.
REQ-041 rst_n pulsed low during EXEC_H of LD16 -> rf_we never asserts, req_ready=0 during reset, req_ready=1 on the first edge after release.
